fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised decoupled fetch stage: generates sequential PCs, issues requests to instruction memory over a valid/ready handshake, and buffers returned instructions in a DEPTH-entry in-order queue feeding decode with valid/ready. Replaces the single-cycle PC register + ROM fetch path so that imem latency and decode stalls no longer stall PC generation. Branch/jump redirects flush the queue and discard every in-flight response of the old stream.

## Interface
- DATA_WIDTH, 32, instruction width
- ADDR_WIDTH, 32, PC width
- DEPTH, 4, queue entries; power of two, ≥2; also the cap on in-flight requests
- RESET_PC, 0, first fetch address after reset

- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- PCSrc  input  1  redirect request (taken branch/jump)
- PC_target  input  ADDR_WIDTH  redirect address; bits [1:0] ignored and treated as 0
- imem_req_valid  output  1  request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  ADDR_WIDTH  request address (word aligned)
- imem_resp_valid  input  1  response valid; in order; cannot be back-pressured
- imem_resp_data  input  DATA_WIDTH  response instruction
- instr_valid  output  1  queue head valid
- instr_ready  input  1  decode accepts head
- Instr  output  DATA_WIDTH  head instruction
- pc_out  output  ADDR_WIDTH  PC of head instruction
- pc_out4  output  ADDR_WIDTH  pc_out + 4, modulo 2^ADDR_WIDTH

## Operation
- State: fetch_pc, queue (instr + pc per entry, rd/wr pointers), occ (0..DEPTH), outst (in-flight, 0..DEPTH), drop (responses to discard, 0..DEPTH). Counters are $clog2(DEPTH)+1 bits.
- Reset (rst=0, asynchronous): fetch_pc=RESET_PC, occ=outst=drop=0, pointers=0; imem_req_valid=0, instr_valid=0, Instr/pc_out/pc_out4 undefined (don't-care).
- Issue: imem_req_valid = !PCSrc && (occ + outst < DEPTH); imem_req_addr = fetch_pc. Request handshake → fetch_pc += 4 (wraps), outst++.
- Response: each imem_resp_valid decrements outst. If drop>0 → discarded, drop--. Else → pushed to queue tail with pc = address of the matching request (tracked by a per-request PC FIFO or a separate resp_pc register advanced by 4).
- The credit rule (occ + outst < DEPTH) guarantees every non-dropped response has a free slot; queue overflow is impossible, and an assertion checks this.
- Dequeue: instr_valid = (occ>0) && !PCSrc. instr_valid && instr_ready → pop, occ--.
- Redirect (PCSrc=1) in cycle N: queue flushed (occ=0, rd=wr), fetch_pc=PC_target&~3, resp_pc=PC_target&~3, drop = outst after counting cycle-N responses (a response arriving in cycle N is discarded regardless), no request issued and no dequeue in cycle N.
- Back-to-back redirects: each one reflushes and recomputes drop; last target wins.
- New-stream requests may issue while drop>0; in-order responses make the drop count sufficient.

## Timing
- After reset release: first request (addr RESET_PC) asserted in the first cycle with rst=1.
- Request accepted in cycle N → response no earlier than N+1 → written at end of response cycle → instr_valid earliest the following cycle (no bypass). With 1-cycle memory: request N, instr_valid N+2.
- Steady state with 1-cycle memory and instr_ready=1: one instruction per cycle when DEPTH ≥ 2.
- Redirect in cycle N → first new-stream request in N+1 at PC_target; its instruction visible no earlier than N+3.
- Simultaneous push and pop: allowed, occ unchanged.
- Full queue (occ=DEPTH): imem_req_valid=0 until a pop.
- imem_req_ready low: address and valid held stable until accepted (unless PCSrc drops valid).

## Test plan
- Reset to RESET_PC=0x100, 1-cycle memory returning addr as data, instr_ready=1 → Instr/pc_out sequence 0x100,0x104,0x108… one per cycle from cycle 2, pc_out4 = pc_out+4.
- instr_ready=0 for 10 cycles, DEPTH=4 → exactly 4 requests issued, imem_req_valid then low; releasing ready drains 0x100..0x10C in order with no loss or duplication.
- 3-cycle memory latency, 2 requests in flight, PCSrc with PC_target=0x203 → both old responses dropped, next request addr 0x200, first delivered instruction has pc_out=0x200.
- Redirect in the same cycle as an old-stream response and instr_ready=1 → response dropped, no pop observed, instr_valid=0 that cycle.
- fetch_pc=0xFFFFFFFC → next request 0x00000000, pc_out4 of head 0xFFFFFFFC is 0x00000000.
- Assert rst=0 mid-stream with 2 in flight and queue half full → outputs invalid immediately (async), after release fetch restarts at RESET_PC and stale responses are not delivered (bench holds memory idle during reset).

Source files
------------

// File: rtl/fetch_queue.sv
// Decoupled fetch: sequential PC generator, credit-limited imem requests, DEPTH-entry in-order instruction queue.
// Request-to-instr_valid >= 2 cycles (no bypass); requests stop when occ+outst reaches DEPTH; redirect blocks issue/dequeue that cycle.
module fetch_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PCSrc,
  input  logic [ADDR_WIDTH-1:0] PC_target,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [DATA_WIDTH-1:0] imem_resp_data,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] Instr,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [ADDR_WIDTH-1:0] pc_out4
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]           CAP   = (CW+1)'(DEPTH);
  localparam logic [CW-1:0]         FULL  = CW'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ALIGN = ~ADDR_WIDTH'(3);

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] resp_pc;
  logic [ADDR_WIDTH-1:0] target;
  logic [DATA_WIDTH-1:0] q_instr [DEPTH];
  logic [ADDR_WIDTH-1:0] q_pc    [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         occ;
  logic [CW-1:0]         outst;
  logic [CW-1:0]         drop;
  logic [CW-1:0]         outst_after_resp;
  logic [CW:0]           credits_used;
  logic                  req_fire;
  logic                  push;
  logic                  pop;

  assign target           = PC_target & ALIGN;
  assign credits_used     = {1'b0, occ} + {1'b0, outst};
  assign imem_req_valid   = rst && !PCSrc && (credits_used < CAP);
  assign imem_req_addr    = fetch_pc;
  assign req_fire         = imem_req_valid && imem_req_ready;
  assign outst_after_resp = outst - CW'(imem_resp_valid);

  // A response during a redirect belongs to the old stream and is always discarded.
  assign push        = imem_resp_valid && (drop == '0) && !PCSrc;
  assign instr_valid = (occ != '0) && !PCSrc;
  assign pop         = instr_valid && instr_ready;

  assign Instr   = q_instr[rd_ptr];
  assign pc_out  = q_pc[rd_ptr];
  assign pc_out4 = pc_out + STEP;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
      outst    <= '0;
      drop     <= '0;
    end else if (PCSrc) begin
      // Everything still in flight after this cycle's response is from the old stream.
      fetch_pc <= target;
      resp_pc  <= target;
      rd_ptr   <= wr_ptr;
      occ      <= '0;
      outst    <= outst_after_resp;
      drop     <= outst_after_resp;
    end else begin
      if (req_fire)
        fetch_pc <= fetch_pc + STEP;
      outst <= outst_after_resp + CW'(req_fire);
      if (imem_resp_valid && (drop != '0))
        drop <= drop - CW'(1);
      if (push) begin
        wr_ptr  <= wr_ptr + PW'(1);
        resp_pc <= resp_pc + STEP;
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      occ <= occ + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= imem_resp_data;
      q_pc[wr_ptr]    <= resp_pc;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) push |-> (occ < FULL || pop));
  a_resp_expected: assert property (@(posedge clk) disable iff (!rst) imem_resp_valid |-> (outst != '0));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: in-order memory model with settable latency, hand-computed expected streams.
module tb_fetch_queue;
  logic        clk;
  logic        rst;
  logic        PCSrc;
  logic [31:0] PC_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] Instr;
  logic [31:0] pc_out;
  logic [31:0] pc_out4;

  int total = 0;
  int bad = 0;
  int cyc;
  int req_cnt;
  int base;
  int mem_lat;
  bit mem_en;
  logic [31:0] mq_addr[$];
  int          mq_due[$];

  fetch_queue #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .DEPTH(4),
    .RESET_PC(32'h100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .PCSrc(PCSrc),
    .PC_target(PC_target),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .Instr(Instr),
    .pc_out(pc_out),
    .pc_out4(pc_out4)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Memory returns the request address as data, in order, mem_lat cycles after acceptance.
  initial begin : mem_model
    logic        s_fire;
    logic        s_resp;
    logic [31:0] s_addr;
    imem_resp_valid = 0;
    imem_resp_data  = '0;
    cyc     = 0;
    req_cnt = 0;
    forever begin
      @(negedge clk);
      s_fire = rst && imem_req_valid && imem_req_ready;
      s_addr = imem_req_addr;
      s_resp = imem_resp_valid;
      @(posedge clk);
      #1;
      cyc++;
      if (!rst) begin
        mq_addr.delete();
        mq_due.delete();
      end else begin
        if (s_resp && mq_addr.size() > 0) begin
          void'(mq_addr.pop_front());
          void'(mq_due.pop_front());
        end
        if (s_fire) begin
          mq_addr.push_back(s_addr);
          mq_due.push_back(cyc + mem_lat - 1);
          req_cnt++;
        end
      end
      if (mem_en && rst && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
        imem_resp_valid = 1;
        imem_resp_data  = mq_addr[0];
      end else begin
        imem_resp_valid = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic enter_reset();
    rst = 0;
    mem_en = 0;
    #1;
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_req_valid", imem_req_valid, 0);
    step();
    step();
  endtask

  task automatic leave_reset();
    mem_en = 1;
    rst = 1;
    #1;
    chk("c0_req_valid", imem_req_valid, 1);
    chk("c0_req_addr", imem_req_addr, 32'h100);
  endtask

  initial begin
    rst = 0; PCSrc = 0; PC_target = '0; imem_req_ready = 1; instr_ready = 1;
    mem_lat = 1; mem_en = 0;

    // Reset, then steady one-per-cycle stream with 1-cycle memory.
    step();
    enter_reset();
    leave_reset();
    step();
    chk("c1_instr_valid", instr_valid, 0);
    step();
    for (int k = 0; k < 4; k++) begin
      chk("stream_valid", instr_valid, 1);
      chk("stream_instr", Instr, 32'h100 + 32'(4 * k));
      chk("stream_pc", pc_out, 32'h100 + 32'(4 * k));
      chk("stream_pc4", pc_out4, 32'h104 + 32'(4 * k));
      step();
    end

    // Decode stalled: credits cap issue at DEPTH, then drain in order.
    enter_reset();
    instr_ready = 0;
    base = req_cnt;
    leave_reset();
    repeat (10) step();
    chk("stall_req_count", 32'(req_cnt - base), 4);
    chk("stall_req_valid", imem_req_valid, 0);
    instr_ready = 1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("drain_valid", instr_valid, 1);
      chk("drain_instr", Instr, 32'h100 + 32'(4 * k));
      chk("drain_pc", pc_out, 32'h100 + 32'(4 * k));
      step();
    end

    // 3-cycle memory: redirect with two in flight, then redirect on an old response.
    enter_reset();
    mem_lat = 3;
    leave_reset();
    step();
    step();
    PCSrc = 1; PC_target = 32'h203;
    #1;
    chk("redir_req_valid", imem_req_valid, 0);
    step();
    PCSrc = 0;
    #1;
    chk("redir_new_valid", imem_req_valid, 1);
    chk("redir_new_addr", imem_req_addr, 32'h200);
    step(); step(); step();
    chk("redir_c6_valid", instr_valid, 0);
    step();
    chk("redir_c7_valid", instr_valid, 1);
    chk("redir_c7_instr", Instr, 32'h200);
    chk("redir_c7_pc", pc_out, 32'h200);
    step();
    chk("c8_pre_valid", instr_valid, 1);
    chk("c8_pre_resp", imem_resp_valid, 1);
    PCSrc = 1; PC_target = 32'h300;
    #1;
    chk("c8_redir_instr_valid", instr_valid, 0);
    chk("c8_redir_req_valid", imem_req_valid, 0);
    step();
    PCSrc = 0;
    #1;
    chk("c9_instr_valid", instr_valid, 0);
    chk("c9_req_addr", imem_req_addr, 32'h300);
    step(); step(); step();
    chk("c12_instr_valid", instr_valid, 0);
    step();
    chk("c13_instr_valid", instr_valid, 1);
    chk("c13_pc", pc_out, 32'h300);
    chk("c13_instr", Instr, 32'h300);

    // Mid-stream reset with two in flight and queue half full.
    enter_reset();
    mem_lat = 2;
    instr_ready = 0;
    leave_reset();
    repeat (4) step();
    chk("mid_pre_valid", instr_valid, 1);
    chk("mid_pre_instr", Instr, 32'h100);
    enter_reset();
    mem_lat = 1;
    instr_ready = 1;
    leave_reset();
    step();
    chk("mid_c1_valid", instr_valid, 0);
    step();
    chk("mid_c2_valid", instr_valid, 1);
    chk("mid_c2_instr", Instr, 32'h100);
    chk("mid_c2_pc", pc_out, 32'h100);

    // Address wrap at the top of the space; low target bits ignored.
    step();
    PCSrc = 1; PC_target = 32'hFFFF_FFFE;
    #1;
    chk("wrap_redir_valid", instr_valid, 0);
    step();
    PCSrc = 0;
    #1;
    chk("wrap_req_valid", imem_req_valid, 1);
    chk("wrap_req_addr0", imem_req_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_req_addr1", imem_req_addr, 32'h0);
    step();
    chk("wrap_head_valid", instr_valid, 1);
    chk("wrap_head_pc", pc_out, 32'hFFFF_FFFC);
    chk("wrap_head_pc4", pc_out4, 32'h0);
    chk("wrap_head_instr", Instr, 32'hFFFF_FFFC);
    step();
    chk("wrap_next_pc", pc_out, 32'h0);
    chk("wrap_next_pc4", pc_out4, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
